// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - MAR/MDR memory responder with wait states and four-phase done handshake
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic [31:0]           mar_addr,
    input  logic [DATA_WIDTH-1:0] mdr_data,
    input  logic                  Read,
    input  logic                  Write,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_done,
    output logic                  busy,
    output logic                  mem_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_CONFLICT = 2'd2
    } op_t;

    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_t                  state, state_d;
    logic [3:0]              cnt, cnt_d;
    logic                    access;
    logic                    capture;
    logic                    err_now;

    op_t                     op_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    oor_q;
    logic [DATA_WIDTH-1:0]   data_q;

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    // Upper address bits are checked at capture so out-of-range requests never alias.
    assign capture = (state == S_IDLE) && (Read || Write);
    assign err_now = (op_q == OP_CONFLICT) || oor_q;

    // State, wait counter and registered handshake outputs.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            mem_done <= 1'b0;
            busy     <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            mem_done <= (state_d == S_DONE);
            busy     <= (state_d != S_IDLE);
            if (access) begin
                mem_err <= err_now;
            end else if (state_d == S_IDLE) begin
                mem_err <= 1'b0;
            end
        end
    end

    // Next-state logic: count down wait states, access once, hold until strobes drop.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        access  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Read || Write) begin
                    state_d = S_WAIT;
                    cnt_d   = 4'(WAIT_STATES);
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_d = cnt - 4'd1;
                end else begin
                    state_d = S_DONE;
                    access  = 1'b1;
                end
            end
            S_DONE: begin
                if (!Read && !Write) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Request capture; only these latched copies are used after IDLE.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_q   <= OP_READ;
            addr_q <= '0;
            oor_q  <= 1'b0;
            data_q <= '0;
        end else if (capture) begin
            if (Read && Write) begin
                op_q <= OP_CONFLICT;
            end else if (Write) begin
                op_q <= OP_WRITE;
            end else begin
                op_q <= OP_READ;
            end
            addr_q <= mar_addr[ADDR_WIDTH-1:0];
            oor_q  <= |(mar_addr >> ADDR_WIDTH);
            data_q <= mdr_data;
        end
    end

    // Read data register; keeps the last successful read until reset.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            Mdatain <= '0;
        end else if (access && (op_q == OP_READ) && !err_now) begin
            Mdatain <= ram[addr_q];
        end
    end

    // RAM write port; contents survive reset, and an aborted request never gets here.
    always_ff @(posedge clock) begin
        if (access && (op_q == OP_WRITE) && !err_now && !clear) begin
            ram[addr_q] <= data_q;
        end
    end

endmodule
